// File: rtl/axi4_drop_req_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_drop_req_arbiter
//  Round-robin arbiter that funnels write-transaction drop requests from
//  NUM_REQ sources into the single trans_id/trans_drop port of the B-channel
//  drop sender. Tracks drops that have been issued but not yet answered on B
//  and stops granting once MAX_OUTSTANDING of them are in flight.
//
//  Optional feature macro: DROP_ARB_STATS_EN
//   When defined, adds per-requester saturating grant counters readable via
//   stat_sel/stat_count and clearable via stat_clr.
// ---------------------------------------------------------------------------
module axi4_drop_req_arbiter #(
  parameter  int NUM_REQ         = 4,
  parameter  int C_AXI_ID_WIDTH  = 10,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int CNT_WIDTH       = 16,
  localparam int ID_W            = C_AXI_ID_WIDTH,
  localparam int OUT_W           = $clog2(MAX_OUTSTANDING + 1),
  localparam int PTR_W           = $clog2(NUM_REQ)
) (
  input  logic                     axi4_aclk,
  input  logic                     axi4_arstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*ID_W-1:0]  req_id,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [ID_W-1:0]          trans_id,
  output logic                     trans_drop,
  input  logic                     trans_ready,
  input  logic                     drop_done,
  output logic [OUT_W-1:0]         outstanding,
`ifdef DROP_ARB_STATS_EN
  input  logic [PTR_W-1:0]         stat_sel,
  input  logic                     stat_clr,
  output logic [CNT_WIDTH-1:0]     stat_count,
`endif
  output logic                     busy,
  output logic                     err_underflow
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [PTR_W-1:0]    rr_ptr_r;
  logic [PTR_W-1:0]    win_r;
  logic [ID_W-1:0]     trans_id_r;
  logic                trans_drop_r;
  logic [OUT_W-1:0]    outstanding_r;
  logic                err_underflow_r;

  logic                win_found_s;
  logic [PTR_W-1:0]    win_idx_s;
  logic [PTR_W-1:0]    idx_s;
  logic [ID_W-1:0]     win_id_s;
  logic                eligible_s;
  logic                grant_s;
  logic                handshake_s;
  logic [NUM_REQ-1:0]  req_ready_s;

  // Round-robin search: first valid requester after rr_ptr, wrapping around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {PTR_W{1'b0}};
    idx_s       = {PTR_W{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      if (!win_found_s && req_valid[idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Select the ID slice belonging to the current winner.
  always_comb begin
    win_id_s = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_s == PTR_W'(i)) begin
        win_id_s = req_id[i*ID_W +: ID_W];
      end else begin
        win_id_s = win_id_s;
      end
    end
  end

  assign eligible_s  = win_found_s && (outstanding_r < OUT_W'(MAX_OUTSTANDING));
  assign grant_s     = (state_r == ST_IDLE) && eligible_s;
  assign handshake_s = (state_r == ST_ISSUE) && trans_ready;

  // One-hot accept strobe, suppressed while reset is asserted.
  always_comb begin
    req_ready_s = {NUM_REQ{1'b0}};
    if (axi4_arstn && grant_s) begin
      req_ready_s[win_idx_s] = 1'b1;
    end else begin
      req_ready_s = {NUM_REQ{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: grant moves to ISSUE, handshake returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (trans_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Latch the winner on grant; hold the sender port until the handshake.
  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      trans_drop_r <= 1'b0;
      trans_id_r   <= {ID_W{1'b0}};
      rr_ptr_r     <= PTR_W'(NUM_REQ - 1);
      win_r        <= {PTR_W{1'b0}};
    end else if (grant_s) begin
      trans_drop_r <= 1'b1;
      trans_id_r   <= win_id_s;
      win_r        <= win_idx_s;
    end else if (handshake_s) begin
      trans_drop_r <= 1'b0;
      rr_ptr_r     <= win_r;
    end else begin
      trans_drop_r <= trans_drop_r;
    end
  end

  // In-flight drop counter plus sticky underflow flag.
  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      outstanding_r   <= {OUT_W{1'b0}};
      err_underflow_r <= 1'b0;
    end else if (handshake_s && drop_done) begin
      outstanding_r <= outstanding_r;
    end else if (handshake_s) begin
      outstanding_r <= outstanding_r + OUT_W'(1);
    end else if (drop_done) begin
      if (outstanding_r == {OUT_W{1'b0}}) begin
        err_underflow_r <= 1'b1;
      end else begin
        outstanding_r <= outstanding_r - OUT_W'(1);
      end
    end else begin
      outstanding_r <= outstanding_r;
    end
  end

`ifdef DROP_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] stat_cnt_r [NUM_REQ];

  // Saturating per-requester grant counters; clear wins over increment.
  always_ff @(posedge axi4_aclk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!axi4_arstn || stat_clr) begin
        stat_cnt_r[i] <= {CNT_WIDTH{1'b0}};
      end else if (req_ready_s[i] && (stat_cnt_r[i] != {CNT_WIDTH{1'b1}})) begin
        stat_cnt_r[i] <= stat_cnt_r[i] + CNT_WIDTH'(1);
      end else begin
        stat_cnt_r[i] <= stat_cnt_r[i];
      end
    end
  end

  // Read port for the selected counter.
  always_comb begin
    stat_count = {CNT_WIDTH{1'b0}};
    if (int'(stat_sel) < NUM_REQ) begin
      stat_count = stat_cnt_r[stat_sel];
    end else begin
      stat_count = {CNT_WIDTH{1'b0}};
    end
  end
`endif

  assign req_ready     = req_ready_s & req_valid;
  assign trans_id      = trans_id_r;
  assign trans_drop    = trans_drop_r;
  assign outstanding   = outstanding_r;
  assign err_underflow = err_underflow_r;
  assign busy          = (state_r != ST_IDLE) || (outstanding_r != {OUT_W{1'b0}});

endmodule

// File: tb/tb_axi4_drop_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_drop_req_arbiter
//  Directed bench: a vector table covers the round-robin rotation and the
//  outstanding/underflow bookkeeping; hand-written sequences cover the
//  back-pressure hold, the MAX_OUTSTANDING throttle and reset mid-ISSUE.
// ---------------------------------------------------------------------------
module tb_axi4_drop_req_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 10;
  localparam int MAXO = 4;
  localparam int CNTW = 16;

  logic                 clk;
  logic                 arstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IDW-1:0]  req_id;
  logic [NREQ-1:0]      req_ready;
  logic [IDW-1:0]       trans_id;
  logic                 trans_drop;
  logic                 trans_ready;
  logic                 drop_done;
  logic [2:0]           outstanding;
  logic                 busy;
  logic                 err_underflow;
`ifdef DROP_ARB_STATS_EN
  logic [1:0]           stat_sel;
  logic                 stat_clr;
  logic [CNTW-1:0]      stat_count;
`endif

  int n_cmp;
  int n_err;

  axi4_drop_req_arbiter #(
    .NUM_REQ(NREQ), .C_AXI_ID_WIDTH(IDW), .MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CNTW)
  ) dut (
    .axi4_aclk    (clk),
    .axi4_arstn   (arstn),
    .req_valid    (req_valid),
    .req_id       (req_id),
    .req_ready    (req_ready),
    .trans_id     (trans_id),
    .trans_drop   (trans_drop),
    .trans_ready  (trans_ready),
    .drop_done    (drop_done),
    .outstanding  (outstanding),
`ifdef DROP_ARB_STATS_EN
    .stat_sel     (stat_sel),
    .stat_clr     (stat_clr),
    .stat_count   (stat_count),
`endif
    .busy         (busy),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       tr;
    logic       dd;
    logic [3:0] exp_rdy;
    logic       exp_drop;
    logic [9:0] exp_id;
    logic [2:0] exp_out;
    logic       exp_err;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int issues;
    bit seen;
    n_cmp = 0;
    n_err = 0;
    arstn       = 1'b0;
    req_valid   = 4'b1111;
    trans_ready = 1'b1;
    drop_done   = 1'b0;
    req_id      = {10'h0A3, 10'h0A2, 10'h0A1, 10'h0A0};
`ifdef DROP_ARB_STATS_EN
    stat_sel = 2'd0;
    stat_clr = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_trans_drop", 32'(trans_drop), 32'h0);
    check("rst_trans_id", 32'(trans_id), 32'h0);
    check("rst_outstanding", 32'(outstanding), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err_underflow), 32'h0);
    arstn = 1'b1;

    // Rotation 0,1,2,3,0 then same-cycle handshake/done and underflow
    vecs[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 10'h0A0, 3'd0, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 10'h0A0, 3'd1, 1'b0};
    vecs[2]  = '{4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 10'h0A1, 3'd0, 1'b0};
    vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 10'h0A1, 3'd1, 1'b0};
    vecs[4]  = '{4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 10'h0A2, 3'd0, 1'b0};
    vecs[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 10'h0A2, 3'd1, 1'b0};
    vecs[6]  = '{4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 10'h0A3, 3'd0, 1'b0};
    vecs[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 10'h0A3, 3'd1, 1'b0};
    vecs[8]  = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 10'h0A0, 3'd0, 1'b0};
    vecs[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 10'h0A0, 3'd1, 1'b0};
    vecs[10] = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 10'h0A1, 3'd1, 1'b0};
    vecs[11] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 10'h0A1, 3'd2, 1'b0};
    vecs[12] = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 10'h0A2, 3'd2, 1'b0};
    vecs[13] = '{4'b1111, 1'b1, 1'b1, 4'b0000, 1'b0, 10'h0A2, 3'd2, 1'b0};
    vecs[14] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 10'h0A2, 3'd1, 1'b0};
    vecs[15] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 10'h0A2, 3'd0, 1'b0};
    vecs[16] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 10'h0A2, 3'd0, 1'b1};
    vecs[17] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 10'h0A2, 3'd0, 1'b1};

    for (int v = 0; v < 18; v++) begin
      req_valid   = vecs[v].valid;
      trans_ready = vecs[v].tr;
      drop_done   = vecs[v].dd;
      #1;
      check($sformatf("v%0d_req_ready", v), 32'(req_ready), 32'(vecs[v].exp_rdy));
      tick();
      check($sformatf("v%0d_trans_drop", v), 32'(trans_drop), 32'(vecs[v].exp_drop));
      check($sformatf("v%0d_trans_id", v), 32'(trans_id), 32'(vecs[v].exp_id));
      check($sformatf("v%0d_outstanding", v), 32'(outstanding), 32'(vecs[v].exp_out));
      check($sformatf("v%0d_err", v), 32'(err_underflow), 32'(vecs[v].exp_err));
    end
    drop_done = 1'b0;

    // Back-pressure: rr_ptr=2, only requester 1 valid, sender stalls 5 cycles
    req_valid   = 4'b0010;
    trans_ready = 1'b0;
    #1;
    check("bp_grant", 32'(req_ready), 32'h2);
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_drop%0d", c), 32'(trans_drop), 32'h1);
      check($sformatf("bp_hold_id%0d", c), 32'(trans_id), 32'h0A1);
      check($sformatf("bp_hold_rdy%0d", c), 32'(req_ready), 32'h0);
      tick();
    end
    req_valid   = 4'b0000;
    trans_ready = 1'b1;
    tick();
    check("bp_done_drop", 32'(trans_drop), 32'h0);
    check("bp_done_out", 32'(outstanding), 32'h1);
    drop_done = 1'b1;
    tick();
    drop_done = 1'b0;
    check("bp_drain_out", 32'(outstanding), 32'h0);

    // Throttle at MAX_OUTSTANDING with requester 2 alone
    req_valid = 4'b0100;
    issues = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (trans_drop) issues++;
    end
    check("thr_issues", 32'(issues), 32'd4);
    check("thr_out", 32'(outstanding), 32'd4);
    check("thr_rdy_blocked", 32'(req_ready), 32'h0);
    check("thr_busy", 32'(busy), 32'h1);
    req_id[2*IDW +: IDW] = 10'h155;
    trans_ready = 1'b0;
    drop_done   = 1'b1;
    tick();
    drop_done = 1'b0;
    check("thr_out_after_done", 32'(outstanding), 32'd3);
    seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (!seen) begin
        tick();
        if (trans_drop) seen = 1'b1;
      end
    end
    check("thr_fifth_issue", 32'(seen), 32'h1);
    check("thr_fifth_id", 32'(trans_id), 32'h155);

    // Reset while holding in ISSUE
    tick();
    check("rst_mid_hold", 32'(trans_drop), 32'h1);
    arstn     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("rst_mid_rdy", 32'(req_ready), 32'h0);
    tick();
    check("rst_mid_drop", 32'(trans_drop), 32'h0);
    check("rst_mid_out", 32'(outstanding), 32'h0);
    check("rst_mid_id", 32'(trans_id), 32'h0);
    arstn       = 1'b1;
    trans_ready = 1'b1;
    #1;
    check("rst_mid_first_winner", 32'(req_ready), 32'h1);
    tick();
    check("rst_mid_first_id", 32'(trans_id), 32'h0A0);

`ifdef DROP_ARB_STATS_EN
    // Statistics: three grants to requester 1, then clear together with a grant
    arstn = 1'b0;
    tick();
    arstn     = 1'b1;
    req_valid = 4'b0010;
    stat_sel  = 2'd1;
    for (int c = 0; c < 6; c++) tick();
    check("stat_count3", 32'(stat_count), 32'd3);
    stat_clr = 1'b1;
    #1;
    check("stat_clr_grant_rdy", 32'(req_ready), 32'h2);
    tick();
    stat_clr = 1'b0;
    check("stat_cleared", 32'(stat_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
